ahb_mem_slave: RTL and testbench
================================

AHB_MEM_SLAVE -- requirements
Module: ahb_mem_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024: memory depth in 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_STATES, default 2: hreadyout-low cycles inserted per data phase, range 0..15.
REQ-003 SHALL have port hclk, input, 1 bit: sole clock, all state on rising edge.
REQ-004 SHALL have port hrstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port hsel, input, 1 bit: slave select.
REQ-006 SHALL have port haddr, input, 32 bits: byte address.
REQ-007 SHALL have port htrans, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-008 SHALL have port hburst, input, 3 bits: burst type; informational only, never alters response.
REQ-009 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-010 SHALL have port hwdata, input, 32 bits: write data, valid in data phase.
REQ-011 SHALL have port hready, input, 1 bit: bus ready; address phase accepted only when high.
REQ-012 SHALL have port hrdata, output, 32 bits: read data.
REQ-013 SHALL have port hreadyout, output, 1 bit: data-phase completion.
REQ-014 SHALL have port hresp, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-015 Address phase SHALL be sampled when hsel & hready & htrans[1]; it captures word index haddr[log2(MEM_WORDS)+1:2], hwrite, and an out-of-range flag (haddr >= 4*MEM_WORDS).
REQ-016 IDLE/BUSY or hsel=0 with hready=1 SHALL produce a zero-wait OKAY response: hreadyout=1, hresp=0, no memory access.
REQ-017 FSM states: IDLE, WAIT, ERR1, ERR2; IDLE -> WAIT on accepted transfer when WAIT_STATES>0, else completes in the following cycle from IDLE.
REQ-018 WAIT SHALL load a down-counter with WAIT_STATES, hold hreadyout=0 while counter>0, and assert hreadyout=1 in the cycle counter reaches 0, then return to IDLE or re-enter WAIT if a new transfer is accepted in that same cycle (back-to-back pipelining).
REQ-019 Reads SHALL drive hrdata = mem[index] in the completing cycle; hrdata is otherwise held at its last value.
REQ-020 Writes SHALL commit hwdata to mem[index] at the rising edge ending the completing cycle (hreadyout=1).
REQ-021 Read directly following a write to the same index SHALL return the newly written data (forward hwdata when the write commits in the read's address phase and WAIT_STATES=0).
REQ-022 Each SEQ beat of a burst (INCR4, WRAP4, etc.) SHALL be a separate pipelined transfer with full WAIT_STATES latency; address sequencing is the master's responsibility.
REQ-023 Byte lanes ignored: all accesses are full-word; haddr[1:0] discarded.

Reset
REQ-024 On hrstn low, immediately: FSM=IDLE, counter=0, hreadyout=1, hresp=0, hrdata=0, pending-transfer flags cleared.
REQ-025 Reset asserted mid-WAIT SHALL abort the transfer with no memory write; memory contents are not reset.
REQ-026 First transfer SHALL be accepted on the first rising edge with hrstn high.

Configuration
REQ-027 Macro AHB_MEM_ERR_RESP_EN defined: out-of-range transfer SHALL skip wait states, go ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE; no memory write; hrdata unchanged.
REQ-028 Macro AHB_MEM_ERR_RESP_EN undefined: ERR1/ERR2 absent, hresp tied 0, out-of-range addresses alias modulo MEM_WORDS.

Verification
REQ-029 WAIT_STATES=2: write 0xDEADBEEF @0x10, read @0x10 -> hreadyout low 2 cycles per phase, read returns 0xDEADBEEF, hresp=0.
REQ-030 WAIT_STATES=0: write 0x12345678 @0x20 immediately followed by read @0x20 -> read completes next cycle with 0x12345678 (forwarding).
REQ-031 Preload words 0x30..0x3C = 1,2,3,4; WRAP4 read NONSEQ 0x38 then SEQ 0x3C,0x30,0x34 -> hrdata sequence 3,4,1,2, each beat WAIT_STATES wait cycles, no idle gaps.
REQ-032 AHB_MEM_ERR_RESP_EN defined, MEM_WORDS=1024: read @0x1000 -> hresp=1 two cycles, hreadyout 0 then 1; undefined -> returns mem[0].
REQ-033 hrstn pulsed low during WAIT of write 0xA5A5A5A5 @0x40 -> hreadyout=1 at once; subsequent read @0x40 returns prior contents.
REQ-034 htrans=BUSY between SEQ beats, and hsel=0 with htrans=NONSEQ -> zero-wait OKAY, memory untouched.

Source files
------------

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-addressed memory slave with WAIT_STATES wait cycles per data phase.
// Define AHB_MEM_ERR_RESP_EN to answer out-of-range addresses with a two-cycle ERROR; otherwise they alias.
module ahb_mem_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hburst,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int AW = $clog2(MEM_WORDS);

`ifdef AHB_MEM_ERR_RESP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT} state_t;
`endif

  state_t        r_state, w_next;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_pend, r_write;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_hrdata, w_rd_data;
  logic [31:0]   r_mem [MEM_WORDS];
  logic          w_hreadyout, w_hresp, w_accept, w_err_acc, w_complete, w_rd_load;
  logic [AW-1:0] w_idx;
  logic          w_unused;

  // hburst and the byte-lane bits never influence the response
  assign w_unused   = ^{hburst, htrans[0], haddr};
  assign w_idx      = haddr[AW+1:2];
  assign w_accept   = hsel & hready & htrans[1] & w_hreadyout;
  assign w_complete = r_pend & w_hreadyout;

`ifdef AHB_MEM_ERR_RESP_EN
  assign w_err_acc = w_accept & (haddr >= 32'(4 * MEM_WORDS));
`else
  assign w_err_acc = 1'b0;
`endif

  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = 1'b0;
    case (r_state)
      ST_WAIT: w_hreadyout = (r_cnt == 4'd0);
`ifdef AHB_MEM_ERR_RESP_EN
      ST_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
      end
      ST_ERR2: w_hresp = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
      w_cnt_nxt = r_cnt - 4'd1;
`ifdef AHB_MEM_ERR_RESP_EN
    end else if (r_state == ST_ERR1) begin
      w_next = ST_ERR2;
`endif
    end else if (w_accept) begin
`ifdef AHB_MEM_ERR_RESP_EN
      if (w_err_acc) begin
        w_next = ST_ERR1;
      end else
`endif
      if (WAIT_STATES > 0) begin
        w_next    = ST_WAIT;
        w_cnt_nxt = 4'(WAIT_STATES);
      end else begin
        w_next = ST_IDLE;
      end
    end else begin
      w_next = ST_IDLE;
    end
  end

  // hrdata is registered, so it is loaded on the edge that opens the completing cycle;
  // with no wait states that edge is also the one committing a preceding write, hence the bypass
  always_comb begin
    w_rd_load = 1'b0;
    w_rd_data = r_mem[r_idx];
    if (WAIT_STATES == 0) begin
      w_rd_load = w_accept & ~hwrite & ~w_err_acc;
      w_rd_data = (w_complete & r_write & (r_idx == w_idx)) ? hwdata : r_mem[w_idx];
    end else begin
      w_rd_load = (r_state == ST_WAIT) & (r_cnt == 4'd1) & ~r_write;
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_pend   <= 1'b0;
      r_hrdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_pend <= ~w_err_acc;
      end else if (w_complete) begin
        r_pend <= 1'b0;
      end
      if (w_rd_load) begin
        r_hrdata <= w_rd_data;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (w_accept) begin
      r_write <= hwrite;
      r_idx   <= w_idx;
    end
  end

  always_ff @(posedge hclk) begin
    if (w_complete & r_write) begin
      r_mem[r_idx] <= hwdata;
    end
  end

  assign hrdata    = r_hrdata;
  assign hreadyout = w_hreadyout;
  assign hresp     = w_hresp;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: one instance with two wait states and one with none, sharing a pipelined master.
module tb_ahb_mem_slave;
`ifdef AHB_MEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hrstn;
  logic        hsel_d, sel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hwrite;
  logic        hsel0, hsel1, hready;
  logic [31:0] rd0, rd1, hrdata_s;
  logic        ro0, ro1, rs0, rs1, hresp_s;

  assign hsel0    = hsel_d & ~sel;
  assign hsel1    = hsel_d & sel;
  assign hready   = sel ? ro1 : ro0;
  assign hrdata_s = sel ? rd1 : rd0;
  assign hresp_s  = sel ? rs1 : rs0;

  always #5 hclk = ~hclk;

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hrdata(rd0), .hreadyout(ro0), .hresp(rs0)
  );

  ahb_mem_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
    .hburst(hburst), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hrdata(rd1), .hreadyout(ro1), .hresp(rs1)
  );

  typedef struct packed {
    logic        hsel;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    int          row;
    logic [3:0]  waits;
    logic        resp;
    logic        chk;
    logic [31:0] data;
    logic [31:0] wdata;
  } sb_t;

  vec_t        tbl [64];
  int          n;
  sb_t         sbq [$];
  logic [31:0] last_rd [2];
  int          checks, errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic hs, input logic [1:0] tr, input logic [2:0] bu, input logic wr,
                     input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] ex);
    tbl[n] = '{hsel: hs, trans: tr, burst: bu, write: wr, addr: ad, wdata: wd, exp: ex};
    n++;
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return ERR_EN && (a >= 32'h1000);
  endfunction

  // Called and returns at a falling edge; rows a..b-1 are issued back-to-back.
  task automatic run_ops(input int a, input int b);
    int   i;
    int   cyc;
    int   waits;
    int   ws;
    sb_t  e;
    i     = a;
    cyc   = 0;
    waits = 0;
    ws    = sel ? 0 : 2;
    while ((i < b || sbq.size() != 0) && cyc < 300) begin
      hwdata = (sbq.size() != 0) ? sbq[0].wdata : 32'h0;
      if (i < b) begin
        hsel_d = tbl[i].hsel;
        htrans = tbl[i].trans;
        hburst = tbl[i].burst;
        hwrite = tbl[i].write;
        haddr  = tbl[i].addr;
      end else begin
        hsel_d = 1'b0;
        htrans = 2'b00;
        hburst = 3'b000;
        hwrite = 1'b0;
        haddr  = 32'h0;
      end
      #1;
      if (sbq.size() != 0) begin
        chk($sformatf("row%0d_hresp", sbq[0].row), {31'b0, hresp_s}, {31'b0, sbq[0].resp});
        if (!hready) begin
          waits++;
        end else begin
          e = sbq.pop_front();
          chk($sformatf("row%0d_waits", e.row), waits, 32'(e.waits));
          if (e.chk) chk($sformatf("row%0d_hrdata", e.row), hrdata_s, e.data);
          waits = 0;
        end
      end
      if (hready && i < b) begin
        e.row   = i;
        e.wdata = tbl[i].wdata;
        if (tbl[i].hsel && tbl[i].trans[1]) begin
          if (is_err(tbl[i].addr)) begin
            e.waits = 4'd1;
            e.resp  = 1'b1;
            e.chk   = 1'b1;
            e.data  = last_rd[sel];
          end else begin
            e.waits = 4'(ws);
            e.resp  = 1'b0;
            e.chk   = ~tbl[i].write;
            e.data  = tbl[i].exp;
            if (!tbl[i].write) last_rd[sel] = tbl[i].exp;
          end
        end else begin
          e.waits = 4'd0;
          e.resp  = 1'b0;
          e.chk   = 1'b1;
          e.data  = last_rd[sel];
        end
        sbq.push_back(e);
        i++;
      end
      cyc++;
      @(negedge hclk);
    end
    if (cyc >= 300) begin
      errors++;
      $display("FAIL run_ops_timeout: rows %0d..%0d stalled, %0d left in queue", a, b - 1, sbq.size());
      sbq.delete();
    end
    hsel_d = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  int na, nb;

  initial begin
    checks = 0; errors = 0; n = 0;
    sel = 1'b0; hsel_d = 1'b0; haddr = 32'h0; htrans = 2'b00; hburst = 3'b000;
    hwrite = 1'b0; hwdata = 32'h0; hrstn = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;

    // two wait states: single write/read, INCR4 fill, WRAP4 read, range and idle cases
    add(1, 2'd2, 3'd0, 1, 32'h10,   32'hDEADBEEF, 32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h10,   32'hF00D0001, 32'hDEADBEEF);
    add(1, 2'd2, 3'd3, 1, 32'h30,   32'h1,        32'h0);
    add(1, 2'd3, 3'd3, 1, 32'h34,   32'h2,        32'h0);
    add(1, 2'd3, 3'd3, 1, 32'h38,   32'h3,        32'h0);
    add(1, 2'd3, 3'd3, 1, 32'h3C,   32'h4,        32'h0);
    add(1, 2'd2, 3'd2, 0, 32'h38,   32'hF00D0002, 32'h3);
    add(1, 2'd3, 3'd2, 0, 32'h3C,   32'hF00D0003, 32'h4);
    add(1, 2'd3, 3'd2, 0, 32'h30,   32'hF00D0004, 32'h1);
    add(1, 2'd3, 3'd2, 0, 32'h34,   32'hF00D0005, 32'h2);
    add(1, 2'd0, 3'd0, 1, 32'h10,   32'hBAD00010, 32'h0);
    add(1, 2'd2, 3'd0, 1, 32'h0,    32'h11110000, 32'h0);
    add(1, 2'd2, 3'd0, 1, 32'h4,    32'h22220000, 32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h1000, 32'hF00D0006, 32'h11110000);
    add(1, 2'd2, 3'd0, 1, 32'h1004, 32'h99999999, 32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h4,    32'hF00D0007, ERR_EN ? 32'h22220000 : 32'h99999999);
    add(1, 2'd2, 3'd0, 0, 32'h0,    32'hF00D0008, 32'h11110000);
    add(1, 2'd2, 3'd1, 0, 32'h30,   32'hF00D0009, 32'h1);
    add(1, 2'd1, 3'd1, 1, 32'h34,   32'hDEAD0001, 32'h0);
    add(1, 2'd3, 3'd1, 0, 32'h34,   32'hF00D000A, 32'h2);
    add(0, 2'd2, 3'd0, 1, 32'h34,   32'hDEAD0002, 32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h34,   32'hF00D000B, 32'h2);
    add(1, 2'd2, 3'd0, 0, 32'h13,   32'hF00D000C, 32'hDEADBEEF);
    add(1, 2'd2, 3'd0, 1, 32'h40,   32'h0F0F0F0F, 32'h0);
    na = n;
    add(1, 2'd2, 3'd0, 0, 32'h40,   32'hF00D000D, 32'h0F0F0F0F);
    nb = n;
    // zero wait states: write-then-read bypass on same and different words
    add(1, 2'd2, 3'd0, 1, 32'h20,   32'h12345678, 32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h20,   32'hF00D000E, 32'h12345678);
    add(1, 2'd2, 3'd0, 1, 32'h24,   32'h5,        32'h0);
    add(1, 2'd2, 3'd0, 1, 32'h28,   32'h77,       32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h24,   32'hF00D000F, 32'h5);
    add(1, 2'd2, 3'd0, 0, 32'h28,   32'hF00D0010, 32'h77);
    add(1, 2'd2, 3'd0, 1, 32'h20,   32'hCAFEF00D, 32'h0);
    add(1, 2'd2, 3'd0, 0, 32'h20,   32'hF00D0011, 32'hCAFEF00D);

    repeat (2) @(negedge hclk);
    chk("reset_hreadyout_ws2", {31'b0, ro0}, 32'h1);
    chk("reset_hresp_ws2",     {31'b0, rs0}, 32'h0);
    chk("reset_hrdata_ws2",    rd0,          32'h0);
    chk("reset_hreadyout_ws0", {31'b0, ro1}, 32'h1);
    chk("reset_hresp_ws0",     {31'b0, rs1}, 32'h0);
    chk("reset_hrdata_ws0",    rd1,          32'h0);
    hrstn = 1'b1;
    run_ops(0, na);

    // reset during the wait of a write must drop it
    hsel_d = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h40; hburst = 3'd0;
    #1;
    chk("midrst_addr_ready", {31'b0, hready}, 32'h1);
    @(negedge hclk);
    hsel_d = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = 32'hA5A5A5A5;
    #1;
    chk("midrst_wait_low", {31'b0, ro0}, 32'h0);
    hrstn = 1'b0;
    #1;
    chk("midrst_hreadyout", {31'b0, ro0}, 32'h1);
    chk("midrst_hresp",     {31'b0, rs0}, 32'h0);
    chk("midrst_hrdata",    rd0,          32'h0);
    @(negedge hclk);
    hrstn = 1'b1;
    hwdata = 32'h0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    run_ops(na, nb);

    sel = 1'b1;
    run_ops(nb, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
